data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: two-requester data-memory bus plus the shared memory port.
// Ports: m0_*/m1_* request fields (req, we, size, addr, wdata) and responses (gnt, rvalid, rdata);
//        mem_we/mem_size/mem_addr/mem_wdata toward memory, mem_rdata back. slave = arbiter, master = requesters + memory.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 10
);
   logic              m0_req;
   logic              m0_we;
   logic [1:0]        m0_size;
   logic [ADDR_W-1:0] m0_addr;
   logic [31:0]       m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [31:0]       m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [1:0]        m1_size;
   logic [ADDR_W-1:0] m1_addr;
   logic [31:0]       m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [31:0]       m1_rdata;

   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_we, mem_size, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_we, mem_size, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-memory port between two requesters m0/m1 (IDLE -> ACCESS -> DONE).
// Ports: clk, rst (sync, active-high), bus (data_mem_arbiter_if.slave). Grant is combinational in IDLE;
//        rvalid arrives LAT+1 cycles after grant. Define ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module data_mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 1
) (
   input  logic clk,
   input  logic rst,
   data_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              owner;
   logic [31:0]       cap;
   logic              any_req;
   logic              win;

`ifndef ARB_FIXED_PRIO_EN
   // rr names the requester that wins the next tie
   logic              rr;
`endif

   assign any_req = bus.m0_req | bus.m1_req;

`ifdef ARB_FIXED_PRIO_EN
   assign win = ~bus.m0_req;
`else
   assign win = (bus.m0_req & bus.m1_req) ? rr : ~bus.m0_req;
`endif

   // rdata is steered to the last owner only; it is meaningful in the DONE cycle
   assign bus.m0_rdata = (owner == 1'b0) ? cap : 32'd0;
   assign bus.m1_rdata = (owner == 1'b1) ? cap : 32'd0;

   always_comb begin
      state_nxt     = state;
      bus.m0_gnt    = 1'b0;
      bus.m1_gnt    = 1'b0;
      bus.m0_rvalid = 1'b0;
      bus.m1_rvalid = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 2'd0;
      bus.mem_addr  = '0;
      bus.mem_wdata = 32'd0;
      case (state)
         IDLE: begin
            if (any_req) begin
               bus.m0_gnt = ~win;
               bus.m1_gnt = win;
               state_nxt  = ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_size  = lat_size;
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
            // counter still at its load value only in the first ACCESS cycle: single write strobe
            bus.mem_we    = lat_we && (cnt == CNT_INIT);
            if (cnt == 4'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.m0_rvalid = ~owner;
            bus.m1_rvalid = owner;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_size  <= 2'd0;
         lat_addr  <= '0;
         lat_wdata <= 32'd0;
         owner     <= 1'b0;
         cap       <= 32'd0;
`ifndef ARB_FIXED_PRIO_EN
         rr        <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_req) begin
                  lat_we    <= win ? bus.m1_we    : bus.m0_we;
                  lat_size  <= win ? bus.m1_size  : bus.m0_size;
                  lat_addr  <= win ? bus.m1_addr  : bus.m0_addr;
                  lat_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
                  owner     <= win;
                  cnt       <= CNT_INIT;
`ifndef ARB_FIXED_PRIO_EN
                  rr        <= ~win;
`endif
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  cap <= lat_we ? 32'd0 : bus.mem_rdata;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed + randomized checks of data_mem_arbiter (LAT=2 main instance, LAT=1 second instance).
// A transaction-timing model (grant at T, memory phase T+1..T+LAT, completion at T+LAT+1) predicts every output each cycle.
// Memory contents are a fixed function of address, so expected read data comes straight from the address.
module tb_data_mem_arbiter;
   localparam int ADDR_W = 10;
   localparam int LAT    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
   data_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

   data_mem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut  (.clk(clk), .rst(rst), .bus(bus));
   data_mem_arbiter #(.ADDR_W(ADDR_W), .LAT(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

   function automatic logic [31:0] mem_val(input logic [ADDR_W-1:0] a);
      if (a == 10'h010) return 32'hDEADBEEF;
      return 32'hA5A50000 ^ (32'(a) * 32'h9E3779B1);
   endfunction

   assign bus.mem_rdata  = mem_val(bus.mem_addr);
   assign bus1.mem_rdata = mem_val(bus1.mem_addr);

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- model: one transaction in flight, timed by cycle arithmetic ----------------
   int                free_at = 0;
   int                last_g  = 1;   // "granted last": 1 so that the first tie goes to m0
   int                t_start = 0;
   int                t_owner = 0;
   logic              t_we;
   logic [1:0]        t_size;
   logic [ADDR_W-1:0] t_addr;
   logic [31:0]       t_wdata;
   logic [31:0]       t_rdata;
   logic [1:0]        model_g = 2'b00;

   always @(negedge clk) begin
      logic              e_rv0, e_rv1, e_we;
      logic [1:0]        e_size;
      logic [ADDR_W-1:0] e_addr;
      logic [31:0]       e_wd;
      int                win;
      e_rv0 = 0; e_rv1 = 0; e_we = 0; e_size = 0; e_addr = 0; e_wd = 0; win = 0;
      model_g = 2'b00;
      if (rst) begin
         free_at = cyc + 1;
         last_g  = 1;
      end else begin
         if (cyc >= free_at) begin
            if (bus.m0_req || bus.m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
               win = bus.m0_req ? 0 : 1;
`else
               if (bus.m0_req && bus.m1_req) win = 1 - last_g;
               else                          win = bus.m0_req ? 0 : 1;
`endif
               t_start = cyc;
               t_owner = win;
               t_we    = (win == 0) ? bus.m0_we    : bus.m1_we;
               t_size  = (win == 0) ? bus.m0_size  : bus.m1_size;
               t_addr  = (win == 0) ? bus.m0_addr  : bus.m1_addr;
               t_wdata = (win == 0) ? bus.m0_wdata : bus.m1_wdata;
               t_rdata = t_we ? 32'd0 : mem_val(t_addr);
               free_at = cyc + LAT + 2;
               last_g  = win;
               model_g[win] = 1'b1;
            end
         end else if (cyc <= t_start + LAT) begin
            e_size = t_size;
            e_addr = t_addr;
            e_wd   = t_wdata;
            e_we   = t_we && (cyc == t_start + 1);
         end else begin
            e_rv0 = (t_owner == 0);
            e_rv1 = (t_owner == 1);
         end
         chk("m0_gnt",    32'(bus.m0_gnt),    32'(model_g[0]));
         chk("m1_gnt",    32'(bus.m1_gnt),    32'(model_g[1]));
         chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(e_rv0));
         chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e_rv1));
         chk("mem_we",    32'(bus.mem_we),    32'(e_we));
         chk("mem_size",  32'(bus.mem_size),  32'(e_size));
         chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
         chk("mem_wdata", bus.mem_wdata, e_wd);
         if (e_rv0) chk("m0_rdata", bus.m0_rdata, t_rdata);
         if (e_rv1) chk("m1_rdata", bus.m1_rdata, t_rdata);
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_m(input int n, input logic req, input logic we, input logic [1:0] size,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
      if (n == 0) begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_size = size; bus.m0_addr = addr; bus.m0_wdata = wd;
      end else begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_size = size; bus.m1_addr = addr; bus.m1_wdata = wd;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_g0"},   32'(bus.m0_gnt),    32'd0);
      chk({tag, "_g1"},   32'(bus.m1_gnt),    32'd0);
      chk({tag, "_rv0"},  32'(bus.m0_rvalid), 32'd0);
      chk({tag, "_rv1"},  32'(bus.m1_rvalid), 32'd0);
      chk({tag, "_we"},   32'(bus.mem_we),    32'd0);
      chk({tag, "_addr"}, 32'(bus.mem_addr),  32'd0);
      chk({tag, "_wd"},   bus.mem_wdata,      32'd0);
      chk({tag, "_rd0"},  bus.m0_rdata,       32'd0);
      chk({tag, "_rd1"},  bus.m1_rdata,       32'd0);
   endtask

   logic pend [2];

   initial begin
      drive_m(0, 0, 0, 0, 0, 0);
      drive_m(1, 0, 0, 0, 0, 0);
      bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_size = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
      bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_size = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
      rst = 1;
      nxt(); nxt(); nxt();
      rst = 0;
      smp(); chk_all_zero("reset");

      // m0 read of 0x010; address changes after grant must not leak to memory
      nxt(); drive_m(0, 1, 0, 2'd2, 10'h010, 32'h0BADF00D);
      smp(); chk("d1_gnt", 32'(bus.m0_gnt), 32'd1);
      nxt(); drive_m(0, 0, 1, 2'd0, 10'h155, 32'h11111111);
      smp(); chk("d1_addr_a", 32'(bus.mem_addr), 32'h010); chk("d1_we", 32'(bus.mem_we), 32'd0);
      nxt();
      smp(); chk("d1_addr_b", 32'(bus.mem_addr), 32'h010);
      nxt();
      smp(); chk("d1_rv0", 32'(bus.m0_rvalid), 32'd1); chk("d1_rdata", bus.m0_rdata, 32'hDEADBEEF);
             chk("d1_rv1", 32'(bus.m1_rvalid), 32'd0);

      // m1 word write to 0x3FC
      nxt(); drive_m(1, 1, 1, 2'd2, 10'h3FC, 32'h12345678);
      smp(); chk("d2_gnt", 32'(bus.m1_gnt), 32'd1);
      nxt(); drive_m(1, 0, 0, 2'd1, 10'h001, 32'hCAFEF00D);
      smp(); chk("d2_we1", 32'(bus.mem_we), 32'd1); chk("d2_wd", bus.mem_wdata, 32'h12345678);
      nxt();
      smp(); chk("d2_we2", 32'(bus.mem_we), 32'd0);
      nxt();
      smp(); chk("d2_rv1", 32'(bus.m1_rvalid), 32'd1); chk("d2_rdata", bus.m1_rdata, 32'd0);

      // both request continuously: one grant per LAT+2 cycles
      for (int i = 0; i < 16; i++) begin
         nxt();
         drive_m(0, 1, 0, 2'd2, 10'h044, 32'd0);
         drive_m(1, 1, 0, 2'd2, 10'h088, 32'd0);
         smp();
`ifdef ARB_FIXED_PRIO_EN
         chk("d3_g0", 32'(bus.m0_gnt), 32'((i % 4) == 0));
         chk("d3_g1", 32'(bus.m1_gnt), 32'd0);
`else
         chk("d3_g0", 32'(bus.m0_gnt), 32'(((i % 4) == 0) && (((i / 4) % 2) == 0)));
         chk("d3_g1", 32'(bus.m1_gnt), 32'(((i % 4) == 0) && (((i / 4) % 2) == 1)));
`endif
      end

      // m1 arrives while m0 is in flight: granted in the first IDLE cycle after m0's DONE
      nxt(); drive_m(0, 1, 0, 2'd0, 10'h0C0, 32'd0); drive_m(1, 0, 0, 0, 0, 0);
      smp(); chk("d4_g0", 32'(bus.m0_gnt), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         nxt(); drive_m(0, 0, 0, 0, 0, 0); drive_m(1, 1, 1, 2'd1, 10'h0C2, 32'h0000BEEF);
         smp(); chk("d4_g1", 32'(bus.m1_gnt), 32'(k == 4));
      end
      drive_m(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) nxt();

      // reset in the middle of an m0 write: aborted, pointer back to favouring m0
      nxt(); drive_m(0, 1, 1, 2'd2, 10'h0F0, 32'h55AA55AA);
      smp(); chk("d5_gnt", 32'(bus.m0_gnt), 32'd1);
      nxt(); drive_m(0, 0, 0, 0, 0, 0); rst = 1;
      nxt(); rst = 0;
      smp(); chk_all_zero("d5_post");
      for (int k = 0; k < 3; k++) begin
         nxt(); smp(); chk("d5_norv0", 32'(bus.m0_rvalid), 32'd0); chk("d5_norv1", 32'(bus.m1_rvalid), 32'd0);
      end
      nxt(); drive_m(0, 1, 0, 2'd2, 10'h100, 32'd0); drive_m(1, 1, 0, 2'd2, 10'h104, 32'd0);
      smp(); chk("d5_tie0", 32'(bus.m0_gnt), 32'd1); chk("d5_tie1", 32'(bus.m1_gnt), 32'd0);
      nxt(); drive_m(0, 0, 0, 0, 0, 0); drive_m(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) nxt();

      // randomized traffic: hold until granted, occasional withdrawal, occasional reset
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst = ($urandom_range(0, 399) == 0);
         for (int n = 0; n < 2; n++) begin
            if (rst || model_g[n]) pend[n] = 0;
            else if (pend[n] && $urandom_range(0, 19) == 0) pend[n] = 0;
            else if (!pend[n] && $urandom_range(0, 2) == 0) begin
               pend[n] = 1;
               drive_m(n, 1, 1'($urandom), 2'($urandom_range(0, 2)), ADDR_W'($urandom), $urandom);
            end
            if (!pend[n])
               drive_m(n, 0, 1'($urandom), 2'($urandom_range(0, 2)), ADDR_W'($urandom), $urandom);
         end
      end
      nxt(); rst = 0; drive_m(0, 0, 0, 0, 0, 0); drive_m(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) nxt();

      // LAT=1 instance: rvalid two cycles after grant, address frozen at grant
      bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_size = 2'd2; bus1.m0_addr = 10'h020;
      smp(); chk("l1_gnt", 32'(bus1.m0_gnt), 32'd1);
      nxt(); bus1.m0_req = 0; bus1.m0_addr = 10'h0AA;
      smp(); chk("l1_addr", 32'(bus1.mem_addr), 32'h020); chk("l1_rv_early", 32'(bus1.m0_rvalid), 32'd0);
      nxt();
      smp(); chk("l1_rv", 32'(bus1.m0_rvalid), 32'd1); chk("l1_rdata", bus1.m0_rdata, mem_val(10'h020));
             chk("l1_rv1", 32'(bus1.m1_rvalid), 32'd0);
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
